// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared encodings, FSM states and helpers for the UART transceiver
package uart_pkg;

   localparam int PAR_NONE = 0;
   localparam int PAR_EVEN = 1;
   localparam int PAR_ODD  = 2;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } uart_state_e;

   function automatic int uart_div(input int clk_hz, input int baud);
      return (clk_hz + 8 * baud) / (16 * baud);
   endfunction

   // Payload arrives zero-extended to 8 bits; the padding does not change the XOR.
   function automatic logic parity_bit(input logic [7:0] payload, input int mode);
      return (mode == PAR_ODD) ? ~(^payload) : ^payload;
   endfunction

endpackage

// File: rtl/uart_fifo.sv
// rtl/uart_fifo.sv - synchronous show-ahead FIFO used for the TX and RX byte queues
module uart_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             push_i,
   input  logic [WIDTH-1:0] push_data_i,
   output logic             full_o,
   input  logic             pop_i,
   output logic [WIDTH-1:0] pop_data_o,
   output logic             empty_o
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic             do_push, do_pop;

   // Pointers carry one wrap bit so full and empty are distinguishable.
   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
   end

   assign pop_data_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/uart_xcvr.sv
// rtl/uart_xcvr.sv - full-duplex UART with 16x oversampled receive and TX/RX byte FIFOs
module uart_xcvr
   import uart_pkg::*;
#(
   parameter int CLK_HZ     = 50_000_000,
   parameter int BAUD       = 115_200,
   parameter int DATA_BITS  = 8,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rx,
   output logic                 tx,
   input  logic [DATA_BITS-1:0] tx_data,
   input  logic                 tx_valid,
   output logic                 tx_ready,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_perr,
   output logic                 rx_ferr,
   output logic                 rx_valid,
   input  logic                 rx_ready,
   output logic                 rx_overrun,
   output logic                 tx_busy
);

   localparam int DIV      = uart_div(CLK_HZ, BAUD);
   localparam int DIV_W    = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int BIT_CLKS = 16 * DIV;
   localparam int BC_W     = $clog2(BIT_CLKS);

   logic [DIV_W-1:0] div_cnt_q;
   logic             tick;

   assign tick = (div_cnt_q == DIV_W'(DIV - 1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)      div_cnt_q <= '0;
      else if (tick) div_cnt_q <= '0;
      else           div_cnt_q <= div_cnt_q + DIV_W'(1);
   end

   logic                   tx_full, tx_empty, tx_pop;
   logic [DATA_BITS-1:0]   tx_fifo_dout;
   logic                   rx_push, rx_full, rx_empty;
   logic [DATA_BITS+1:0]   rx_fifo_din, rx_fifo_dout;

   uart_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
      .clk_i(clk), .rst_ni(rst),
      .push_i(tx_valid), .push_data_i(tx_data), .full_o(tx_full),
      .pop_i(tx_pop), .pop_data_o(tx_fifo_dout), .empty_o(tx_empty)
   );

   uart_fifo #(.WIDTH(DATA_BITS + 2), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
      .clk_i(clk), .rst_ni(rst),
      .push_i(rx_push), .push_data_i(rx_fifo_din), .full_o(rx_full),
      .pop_i(rx_ready), .pop_data_o(rx_fifo_dout), .empty_o(rx_empty)
   );

   assign tx_ready = !tx_full;
   assign rx_valid = !rx_empty;
   assign rx_data  = rx_fifo_dout[DATA_BITS-1:0];
   assign rx_perr  = rx_fifo_dout[DATA_BITS];
   assign rx_ferr  = rx_fifo_dout[DATA_BITS+1];

   logic                 rx_s1_q, rx_s2_q, rx_prev_q;
   uart_state_e          rx_state_q, rx_state_d;
   logic [3:0]           rx_tick_q, rx_tick_d;
   logic [2:0]           rx_idx_q, rx_idx_d;
   logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
   logic                 rx_s7_q, rx_s7_d, rx_s8_q, rx_s8_d;
   logic                 rx_perr_q, rx_perr_d;
   logic                 rx_overrun_q;
   logic                 rx_maj, rx_at9, rx_at15;

   assign rx_maj  = (rx_s7_q & rx_s8_q) | (rx_s7_q & rx_s2_q) | (rx_s8_q & rx_s2_q);
   assign rx_at9  = tick && (rx_tick_q == 4'd9);
   assign rx_at15 = tick && (rx_tick_q == 4'd15);
   assign rx_fifo_din = {~rx_maj, rx_perr_q, rx_shift_q};

   always_comb begin
      rx_state_d = rx_state_q;
      rx_tick_d  = rx_tick_q;
      rx_idx_d   = rx_idx_q;
      rx_shift_d = rx_shift_q;
      rx_s7_d    = rx_s7_q;
      rx_s8_d    = rx_s8_q;
      rx_perr_d  = rx_perr_q;
      rx_push    = 1'b0;
      if (tick) begin
         rx_tick_d = rx_tick_q + 4'd1;
         if (rx_tick_q == 4'd7) rx_s7_d = rx_s2_q;
         if (rx_tick_q == 4'd8) rx_s8_d = rx_s2_q;
      end
      case (rx_state_q)
         S_IDLE: begin
            rx_tick_d = '0;
            if (rx_prev_q && !rx_s2_q) begin
               rx_state_d = S_START;
               rx_idx_d   = '0;
               rx_perr_d  = 1'b0;
            end
         end
         S_START: begin
            if (tick && (rx_tick_q == 4'd8) && rx_s2_q) rx_state_d = S_IDLE;
            else if (rx_at15)                          rx_state_d = S_DATA;
         end
         S_DATA: begin
            if (rx_at9) rx_shift_d = {rx_maj, rx_shift_q[DATA_BITS-1:1]};
            if (rx_at15) begin
               if (rx_idx_q == 3'(DATA_BITS - 1)) begin
                  rx_idx_d   = '0;
                  rx_state_d = (PARITY != PAR_NONE) ? S_PARITY : S_STOP;
               end else begin
                  rx_idx_d = rx_idx_q + 3'd1;
               end
            end
         end
         S_PARITY: begin
            if (rx_at9)  rx_perr_d  = (rx_maj != parity_bit(8'(rx_shift_q), PARITY));
            if (rx_at15) rx_state_d = S_STOP;
         end
         S_STOP: begin
            // Frame completes mid stop bit so a back-to-back start edge is never missed.
            if (rx_at9) begin
               rx_push    = 1'b1;
               rx_state_d = S_IDLE;
            end
         end
         default: rx_state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rx_s1_q      <= 1'b1;
         rx_s2_q      <= 1'b1;
         rx_prev_q    <= 1'b1;
         rx_state_q   <= S_IDLE;
         rx_tick_q    <= '0;
         rx_idx_q     <= '0;
         rx_shift_q   <= '0;
         rx_s7_q      <= 1'b1;
         rx_s8_q      <= 1'b1;
         rx_perr_q    <= 1'b0;
         rx_overrun_q <= 1'b0;
      end else begin
         rx_s1_q      <= rx;
         rx_s2_q      <= rx_s1_q;
         rx_prev_q    <= rx_s2_q;
         rx_state_q   <= rx_state_d;
         rx_tick_q    <= rx_tick_d;
         rx_idx_q     <= rx_idx_d;
         rx_shift_q   <= rx_shift_d;
         rx_s7_q      <= rx_s7_d;
         rx_s8_q      <= rx_s8_d;
         rx_perr_q    <= rx_perr_d;
         rx_overrun_q <= rx_push && rx_full;
      end
   end

   assign rx_overrun = rx_overrun_q;

   uart_state_e          tx_state_q, tx_state_d;
   logic [BC_W-1:0]      tx_cnt_q, tx_cnt_d;
   logic [2:0]           tx_idx_q, tx_idx_d;
   logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
   logic                 tx_par_q, tx_par_d;
   logic                 tx_q, tx_d;
   logic                 tx_busy_q;
   logic                 tx_bit_end;

   assign tx_bit_end = (tx_cnt_q == BC_W'(BIT_CLKS - 1));

   always_comb begin
      tx_state_d = tx_state_q;
      tx_idx_d   = tx_idx_q;
      tx_shift_d = tx_shift_q;
      tx_par_d   = tx_par_q;
      tx_pop     = 1'b0;
      tx_cnt_d   = (tx_state_q == S_IDLE || tx_bit_end) ? '0 : tx_cnt_q + BC_W'(1);
      case (tx_state_q)
         S_IDLE: begin
            if (!tx_empty) begin
               tx_pop     = 1'b1;
               tx_shift_d = tx_fifo_dout;
               tx_par_d   = parity_bit(8'(tx_fifo_dout), PARITY);
               tx_state_d = S_START;
            end
         end
         S_START: begin
            if (tx_bit_end) begin
               tx_state_d = S_DATA;
               tx_idx_d   = '0;
            end
         end
         S_DATA: begin
            if (tx_bit_end) begin
               tx_shift_d = {1'b0, tx_shift_q[DATA_BITS-1:1]};
               if (tx_idx_q == 3'(DATA_BITS - 1)) begin
                  tx_idx_d   = '0;
                  tx_state_d = (PARITY != PAR_NONE) ? S_PARITY : S_STOP;
               end else begin
                  tx_idx_d = tx_idx_q + 3'd1;
               end
            end
         end
         S_PARITY: begin
            if (tx_bit_end) begin
               tx_state_d = S_STOP;
               tx_idx_d   = '0;
            end
         end
         S_STOP: begin
            if (tx_bit_end) begin
               if (tx_idx_q != 3'(STOP_BITS - 1)) begin
                  tx_idx_d = tx_idx_q + 3'd1;
               end else if (!tx_empty) begin
                  tx_pop     = 1'b1;
                  tx_shift_d = tx_fifo_dout;
                  tx_par_d   = parity_bit(8'(tx_fifo_dout), PARITY);
                  tx_state_d = S_START;
               end else begin
                  tx_state_d = S_IDLE;
               end
            end
         end
         default: tx_state_d = S_IDLE;
      endcase
      case (tx_state_q)
         S_START:  tx_d = 1'b0;
         S_DATA:   tx_d = tx_shift_q[0];
         S_PARITY: tx_d = tx_par_q;
         default:  tx_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tx_state_q <= S_IDLE;
         tx_cnt_q   <= '0;
         tx_idx_q   <= '0;
         tx_shift_q <= '0;
         tx_par_q   <= 1'b0;
         tx_q       <= 1'b1;
         tx_busy_q  <= 1'b0;
      end else begin
         tx_state_q <= tx_state_d;
         tx_cnt_q   <= tx_cnt_d;
         tx_idx_q   <= tx_idx_d;
         tx_shift_q <= tx_shift_d;
         tx_par_q   <= tx_par_d;
         tx_q       <= tx_d;
         tx_busy_q  <= !tx_empty || (tx_state_q != S_IDLE);
      end
   end

   assign tx      = tx_q;
   assign tx_busy = tx_busy_q;

endmodule

// File: doc/uart_xcvr.md
# uart_xcvr

Parametrised full-duplex UART transceiver with 16x oversampled receive, configurable frame format (data bits, parity, stop bits) and independent TX/RX FIFOs. It takes the place of the fixed 8N1 receiver/transmitter pair below the command/control layer. Controllers see two valid/ready byte streams and never handle bit timing.

## Interface
- CLK_HZ, 50_000_000, system clock frequency
- BAUD, 115_200, line rate
- DATA_BITS, 8, payload bits per frame, legal 5..8
- PARITY, 0, 0 none / 1 even / 2 odd
- STOP_BITS, 1, TX stop bits, 1 or 2
- FIFO_DEPTH, 16, entries per FIFO, power of two ≥ 2

- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- rx  in  1  serial input, asynchronous to clk
- tx  out  1  serial output, idle high
- tx_data  in  DATA_BITS  byte to send
- tx_valid  in  1  push request
- tx_ready  out  1  TX FIFO not full
- rx_data  out  DATA_BITS  head of RX FIFO (show-ahead)
- rx_perr  out  1  parity error flag stored with rx_data
- rx_ferr  out  1  framing error flag stored with rx_data
- rx_valid  out  1  RX FIFO not empty
- rx_ready  in  1  pop request
- rx_overrun  out  1  one-cycle pulse: received frame dropped, RX FIFO full
- tx_busy  out  1  TX FIFO non-empty or frame in progress

## Operation
- Oversample divider DIV = (CLK_HZ + 8·BAUD) / (16·BAUD), integer; free-running counter gives 1-clk tick every DIV clocks. One bit = 16 ticks.
- RX path: 2-flop synchroniser (reset to 1) → FSM IDLE, START, DATA, PARITY, STOP.
  - IDLE: synchronised falling edge → START, tick count cleared.
  - START: at tick 8 line still 0 → DATA; else glitch → IDLE, nothing pushed.
  - DATA: bits LSB first, each a 2-of-3 majority of ticks 7, 8, 9 of its bit.
  - PARITY (skipped if PARITY=0): mismatch sets perr.
  - STOP: majority sample 0 sets ferr. At tick 9 push {ferr, perr, data} → IDLE. Only the first stop bit is checked.
  - Push while RX FIFO full: frame discarded, rx_overrun pulses 1 clk, FIFO contents untouched.
- TX path: FSM IDLE, START, DATA, PARITY, STOP with own bit-length counter of 16·DIV clocks (not the shared tick).
  - IDLE with TX FIFO non-empty: pop, load shifter → START.
  - Parity over DATA_BITS payload bits only; even means total ones, parity included, is even.
  - STOP lasts STOP_BITS bit times. If the FIFO is non-empty at its end, the next START follows with no idle gap.
- FIFOs: synchronous, show-ahead; push ignored when full, pop ignored when empty; simultaneous push+pop when neither full nor empty leaves count unchanged.

## Timing
- Reset values: tx=1, tx_ready=1, tx_busy=0, rx_valid=0, rx_data=0, rx_perr=0, rx_ferr=0, rx_overrun=0; both FSMs IDLE, FIFOs empty.
- Reset mid-frame: tx forced high asynchronously, partial frames and all FIFO contents lost.
- TX latency: handshake (tx_valid & tx_ready) at edge N with FSM idle and FIFO empty → tx low from edge N+2. tx_busy high from edge N+1.
- Each TX bit exactly 16·DIV clocks. Frame = (1 + DATA_BITS + (PARITY≠0) + STOP_BITS) bit times.
- RX: rx_valid rises 1 clk after the stop-bit tick-9 push. Sync delay of 2 clks is included in the sample-point budget.
- tx_ready drops the cycle after the FIFO_DEPTH-th unpopped push.

## Structure
- Package uart_pkg: parity encodings PAR_NONE/PAR_EVEN/PAR_ODD, FSM state enum, DIV computation function.
- One sub-module uart_fifo (WIDTH, DEPTH), instantiated twice: TX width DATA_BITS, RX width DATA_BITS+2.
- RX and TX FSMs inline in uart_xcvr.

## Test plan
Sim parameters: CLK_HZ=1_600_000, BAUD=100_000, so DIV=1 and a bit is 16 clks.
- Default 8N1, push 0x55 at idle → tx low from edge N+2; line pattern 0,1,0,1,0,1,0,1,0,1, each 16 clks; tx_busy falls after stop.
- Loop tx→rx, PARITY=1, push 0xA3, 0x00, 0xFF back-to-back → no idle gaps; RX pops 0xA3, 0x00, 0xFF with perr=0 and ferr=0.
- PARITY=2, inject frame 0x0F carrying wrong parity → rx_data=0x0F, rx_perr=1. Inject stop bit 0 → rx_ferr=1, byte still delivered.
- 6-clk low glitch on idle rx → no push, rx_valid stays 0.
- FIFO_DEPTH=4, rx_ready=0, send 5 frames → rx_valid=1, 4 entries intact, one 1-clk rx_overrun pulse on 5th. Push 5 TX bytes with TX stalled → tx_ready=0 after 4th accepted.
- Assert rst low mid-DATA of a TX frame → tx=1 immediately, tx_ready=1, rx_valid=0; after release the next push transmits cleanly.
